alu_div_seq: RTL
================

// Module: alu_div_seq
// PURPOSE
// - Multi-cycle divide sequencer. Implements ALU_OP_DIV by driving the shared ALU with ALU_OP_DIF.
// - Runs one restoring-division step per cycle.
// - Sits beside the execute stage. While busy it owns the ALU ports through an external mux selected by alu_busy.
// - Request and response use valid/ready handshakes. Returns quotient and remainder.
// PARAMETERS
// - WIDTH  32  operand/result width; must be >= 2
// PORTS
// - clk          in   1      clock; all state updates on rising edge
// - rst          in   1      synchronous, active-high reset
// - req_valid    in   1      request present
// - req_ready    out  1      block can accept a request (state IDLE)
// - req_dividend in   WIDTH  dividend
// - req_divisor  in   WIDTH  divisor
// - req_signed   in   1      signed divide (honoured only with DIV_SIGNED_EN)
// - resp_valid   out  1      result available (state DONE)
// - resp_ready   in   1      consumer takes result
// - resp_quot    out  WIDTH  quotient
// - resp_rem     out  WIDTH  remainder
// - resp_divz    out  1      divisor was zero
// - alu_busy     out  1      sequencer owns ALU (state BUSY)
// - alu_op1      out  WIDTH  ALU operand 1 (partial remainder, shifted)
// - alu_op2      out  WIDTH  ALU operand 2 (divisor magnitude)
// - alu_ctrl     out  4      constant ALU_OP_DIF
// - alu_result   in   WIDTH  ALU difference
// - alu_flags    in   4      {N,Z,C,V}; C=1 on subtract means no borrow
// BEHAVIOUR
// - Reset: state IDLE, count 0, all datapath regs 0.
//   Outputs: req_ready=1, resp_valid=0, alu_busy=0, resp_quot/rem/divz=0.
// - FSM IDLE->BUSY: on req_valid&req_ready with divisor!=0.
//   Latch Q=|dividend|, D=|divisor|, R=0, count=WIDTH.
// - FSM IDLE->DONE: on accept with divisor==0, one edge later.
//   quot=all ones, rem=dividend (raw, no sign handling), divz=1.
// - BUSY step (one per cycle):
//   - sh={R[W-2:0],Q[W-1]}; msb=R[W-1].
//   - alu_op1=sh, alu_op2=D.
//   - take = msb | alu_flags[C].
//   - R <= take ? alu_result : sh; Q <= {Q[W-2:0],take}; count--.
// - BUSY->DONE: on the edge where count goes 1->0.
//   resp_valid rises exactly WIDTH edges after the accepting edge.
// - DONE: quot/rem/divz held stable while resp_valid&!resp_ready.
//   DONE->IDLE on resp_ready. req_ready=0 in DONE; no same-cycle re-accept.
// - alu_op1/op2 = 0 outside BUSY; alu_ctrl always 4'b0001.
// - Ignored inputs: req_* ignored outside IDLE; resp_ready ignored outside DONE.
// - Reset mid-operation: the reset edge returns to IDLE.
//   The in-flight request is discarded and no response is produced.
// - Arithmetic: unsigned modulo 2^WIDTH.
//   Quotient and remainder satisfy dividend = quot*divisor + rem, with rem < divisor.
// CONFIGURATION
// - DIV_SIGNED_EN defined, req_signed=1:
//   - Operands are converted to magnitudes (two's-complement negate) at accept; signs are latched.
//   - The final step negates the quotient if the operand signs differ.
//   - The final step negates the remainder if the dividend is negative (truncating division).
//   - MIN/-1 gives quot=MIN, rem=0, with no special case.
//   - Latency is unchanged.
// - DIV_SIGNED_EN undefined:
//   - req_signed is ignored and all divides are unsigned.
//   - No sign registers or negators are built.
// STRUCTURE
// - alu_pkg (shared with the ALU): alu_op enum, ALU_OP_DIF/ALU_OP_DIV constants, flag indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
// - Local typedef: div_state_t {IDLE, BUSY, DONE}.
// - Counter width $clog2(WIDTH)+1.
// - No sub-module. The ALU is instantiated and muxed at the execute-stage top, not inside this block.
// TESTING (WIDTH=32, bench models the ALU)
// - 100/7 unsigned:
//   - resp_valid 32 edges after accept.
//   - quot=14, rem=2, divz=0.
//   - alu_busy high exactly 32 cycles.
// - 0xFFFFFFFF/1: quot=0xFFFFFFFF, rem=0.
// - 0x80000000/0xFFFFFFFF unsigned: quot=0, rem=0x80000000.
// - 5/0:
//   - resp_valid after 1 edge; quot=0xFFFFFFFF, rem=5, divz=1.
//   - alu_busy never high.
// - Backpressure: hold resp_ready=0 for 10 cycles.
//   - Outputs stable, req_ready=0.
//   - Raise resp_ready: IDLE next edge, new request accepted.
// - Reset mid-op: assert rst at step 12.
//   - Next cycle: req_ready=1, resp_valid=0.
//   - A new 9/3 gives quot=3, rem=0.
// - With DIV_SIGNED_EN:
//   - -7/2 gives quot=0xFFFFFFFD, rem=0xFFFFFFFF.
//   - 0x80000000/-1 gives quot=0x80000000, rem=0.
//   - The same -7/2 request with req_signed=0 gives the unsigned result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD = 4'd0,
    ALU_OP_DIF = 4'd1,
    ALU_OP_AND = 4'd2,
    ALU_OP_OR  = 4'd3,
    ALU_OP_XOR = 4'd4,
    ALU_OP_SHL = 4'd5,
    ALU_OP_SHR = 4'd6,
    ALU_OP_MUL = 4'd7,
    ALU_OP_DIV = 4'd8
  } alu_op;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider that borrows the shared ALU for its subtract steps.
// Optional signed support is enabled by defining DIV_SIGNED_EN.
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  input  logic             req_signed,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_quot,
  output logic [WIDTH-1:0] resp_rem,
  output logic             resp_divz,
  output logic             alu_busy,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t state_q, state_d;

  logic [WIDTH-1:0] q_q, r_q, d_q;
  logic [CW-1:0]    count_q;
  logic             divz_q;

  logic [WIDTH-1:0] sh, q_step, r_step, q_fin, r_fin;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             take, accept, divz_in, last_step;
  logic             unused_in;

  always_comb begin
    sh        = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    // R's dropped MSB acts as bit WIDTH of the partial remainder, so it always forces a subtract
    take      = r_q[WIDTH-1] | alu_flags[FLAG_C];
    q_step    = {q_q[WIDTH-2:0], take};
    r_step    = take ? alu_result : sh;
    accept    = req_valid && (state_q == IDLE);
    divz_in   = (req_divisor == '0);
    last_step = (count_q == CW'(1));
  end

`ifdef DIV_SIGNED_EN
  logic dvd_neg, dvs_neg, neg_quot_q, neg_rem_q;

  always_comb begin
    dvd_neg = req_signed & req_dividend[WIDTH-1];
    dvs_neg = req_signed & req_divisor[WIDTH-1];
    dvd_mag = dvd_neg ? -req_dividend : req_dividend;
    dvs_mag = dvs_neg ? -req_divisor  : req_divisor;
    q_fin   = neg_quot_q ? -q_step : q_step;
    r_fin   = neg_rem_q  ? -r_step : r_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (accept && !divz_in) begin
      neg_quot_q <= dvd_neg ^ dvs_neg;
      neg_rem_q  <= dvd_neg;
    end
  end

  assign unused_in = ^{alu_flags[FLAG_N], alu_flags[FLAG_Z], alu_flags[FLAG_V]};
`else
  always_comb begin
    dvd_mag = req_dividend;
    dvs_mag = req_divisor;
    q_fin   = q_step;
    r_fin   = r_step;
  end

  assign unused_in = ^{alu_flags[FLAG_N], alu_flags[FLAG_Z], alu_flags[FLAG_V], req_signed};
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = divz_in ? DONE : BUSY;
      BUSY: if (last_step) state_d = DONE;
      DONE: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      divz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (divz_in) begin
              q_q    <= '1;
              r_q    <= req_dividend;
              divz_q <= 1'b1;
            end else begin
              q_q     <= dvd_mag;
              r_q     <= '0;
              d_q     <= dvs_mag;
              count_q <= CW'(WIDTH);
              divz_q  <= 1'b0;
            end
          end
        end
        BUSY: begin
          q_q     <= last_step ? q_fin : q_step;
          r_q     <= last_step ? r_fin : r_step;
          count_q <= count_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign alu_busy   = (state_q == BUSY);
  assign alu_op1    = alu_busy ? sh  : '0;
  assign alu_op2    = alu_busy ? d_q : '0;
  assign alu_ctrl   = ALU_OP_DIF;
  assign resp_quot  = q_q;
  assign resp_rem   = r_q;
  assign resp_divz  = divz_q;

endmodule
